// File: rtl/btb_update_queue_pkg.sv
// Shared BTB definitions: PC field slices and the resolved-branch record
// that the update queue, BTB write stage and BTB file all agree on.
package btb_update_queue_pkg;

    localparam int PC_W    = 32;
    localparam int SET_MSB = 4;
    localparam int SET_LSB = 2;
    localparam int SET_W   = SET_MSB - SET_LSB + 1;
    localparam int TAG_LSB = 5;
    localparam int TAG_W   = PC_W - TAG_LSB;

    typedef logic [SET_W-1:0] btb_set_t;
    typedef logic [TAG_W-1:0] btb_tag_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } btb_rec_t;

    function automatic btb_set_t btb_set_idx(input logic [PC_W-1:0] pc);
        return pc[SET_MSB:SET_LSB];
    endfunction

    function automatic btb_tag_t btb_tag(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:TAG_LSB];
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Record FIFO for the BTB update queue: storage, wrapping binary pointers
// and an occupancy counter; full/empty come only from registered occupancy.
module btb_upd_fifo
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  btb_rec_t wdata,
    input  logic     pop,
    output btb_rec_t head,
    output logic     empty,
    output logic     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    btb_rec_t        mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;

    // Gate requests against current occupancy so a bad request cannot corrupt state.
    always_comb begin
        push_s = push && !full;
        pop_s  = pop && !empty;
    end

    // Record storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == {CW{1'b0}});
    assign full  = (count_r == DEPTH_C);

endmodule

// File: rtl/btb_update_queue.sv
// Queues resolved branches from execute and issues them to the BTB as a
// set read followed one cycle later by an update, avoiding same-set reads.
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            res_valid,
    input  logic [31:0]     res_pc,
    input  logic            res_taken,
    input  logic [31:0]     res_target,
    output logic            res_ready,
    output logic            rd_req_en,
    output logic [2:0]      rd_req_set,
    output logic            update_en,
    output logic [31:0]     update_pc,
    output logic            actual_taken,
    output logic [31:0]     update_target,
    output logic            busy,
    output logic [CNTW-1:0] drop_cnt
);

    btb_rec_t        wdata_s;
    btb_rec_t        head_s;
    btb_rec_t        u_rec_r;
    logic            u_valid_r;
    logic            empty_s;
    logic            full_s;
    logic            stall_s;
    logic            issue_s;
    logic            push_s;
    logic            drop_s;
    logic [CNTW-1:0] drop_cnt_r;

    assign wdata_s = '{pc: res_pc, taken: res_taken, target: res_target};

    btb_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (wdata_s),
        .pop   (issue_s),
        .head  (head_s),
        .empty (empty_s),
        .full  (full_s)
    );

    // Hold the head back one cycle when U is about to write the same set.
    always_comb begin
        stall_s = 1'b0;
        if (u_valid_r && (btb_set_idx(head_s.pc) == btb_set_idx(u_rec_r.pc))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
        issue_s = !empty_s && !stall_s;
        push_s  = res_valid && !full_s;
        drop_s  = res_valid && full_s;
    end

    // Update register U: loaded on issue, cleared (valid and fields) otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_valid_r <= 1'b0;
            u_rec_r   <= '0;
        end else if (issue_s) begin
            u_valid_r <= 1'b1;
            u_rec_r   <= head_s;
        end else begin
            u_valid_r <= 1'b0;
            u_rec_r   <= '0;
        end
    end

    // Saturating count of records refused while the FIFO was full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_r <= '0;
        end else if (drop_s && (drop_cnt_r != {CNTW{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + CNTW'(1);
        end
    end

    assign res_ready     = !full_s;
    assign rd_req_en     = issue_s;
    assign rd_req_set    = issue_s ? btb_set_idx(head_s.pc) : 3'b000;
    assign update_en     = u_valid_r;
    assign update_pc     = u_rec_r.pc;
    assign actual_taken  = u_rec_r.taken;
    assign update_target = u_rec_r.target;
    assign busy          = !empty_s || u_valid_r;
    assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue: directed records, expected updates
// queued at issue, a negedge monitor pops and compares each update_en.
module tb_btb_update_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = 32'h0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = 32'h0;
    logic        res_ready;
    logic        rd_req_en;
    logic [2:0]  rd_req_set;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic [31:0] update_target;
    logic        busy;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit sb_off = 1'b0;
    int t0;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];
    int   rd_cyc[$];
    int   rd_set[$];
    int   upd_cyc[$];

    btb_update_queue #(
        .DEPTH (4),
        .CNTW  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .res_valid     (res_valid),
        .res_pc        (res_pc),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .res_ready     (res_ready),
        .rd_req_en     (rd_req_en),
        .rd_req_set    (rd_req_set),
        .update_en     (update_en),
        .update_pc     (update_pc),
        .actual_taken  (actual_taken),
        .update_target (update_target),
        .busy          (busy),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Monitor: log read/update cycles and score every update against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!sb_off) begin
                if (rd_req_en) begin
                    rd_cyc.push_back(cyc);
                    rd_set.push_back(int'(rd_req_set));
                end
                if (update_en) begin
                    upd_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_update actual pc=0x%0h required=no update", update_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("upd_pc", 64'(update_pc), 64'(e.pc));
                        chk("upd_taken", 64'(actual_taken), 64'(e.taken));
                        chk("upd_target", 64'(update_target), 64'(e.target));
                    end
                end
            end
        end
    end

    task automatic push_rec(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                            input bit expect_upd);
        res_valid  = 1'b1;
        res_pc     = pc;
        res_taken  = tk;
        res_target = tg;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        if (expect_upd) sb.push_back('{pc, tk, tg});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_cyc.delete();
        rd_set.delete();
        upd_cyc.delete();
    endtask

    // Timing below: t0 is the accept edge; rd_req_en is seen in the cycle
    // starting at t0 and update_en in the cycle starting at t0+1.
    initial begin
        // Reset state
        idle(2);
        chk("rst_res_ready", 64'(res_ready), 64'(1));
        chk("rst_rd_req_en", 64'(rd_req_en), 64'(0));
        chk("rst_update_en", 64'(update_en), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        rst = 1'b1;
        idle(1);

        // Single record
        clear_logs();
        push_rec(32'h0000_1008, 1'b1, 32'h0000_2000, 1'b1);
        t0 = cyc;
        idle(5);
        chk("single_rd_count", 64'(rd_cyc.size()), 64'(1));
        chk("single_rd_cyc", 64'(at(rd_cyc, 0)), 64'(t0));
        chk("single_rd_set", 64'(at(rd_set, 0)), 64'(2));
        chk("single_upd_cyc", 64'(at(upd_cyc, 0)), 64'(t0 + 1));
        chk("idle_update_pc", 64'(update_pc), 64'(0));
        chk("idle_actual_taken", 64'(actual_taken), 64'(0));
        chk("idle_update_target", 64'(update_target), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));

        // Same set back to back: second read delayed by one cycle
        clear_logs();
        push_rec(32'h0000_0004, 1'b0, 32'h0000_0400, 1'b1);
        t0 = cyc;
        push_rec(32'h0000_0024, 1'b1, 32'h0000_0800, 1'b1);
        idle(6);
        chk("same_rd_cyc0", 64'(at(rd_cyc, 0)), 64'(t0));
        chk("same_rd_cyc1", 64'(at(rd_cyc, 1)), 64'(t0 + 2));
        chk("same_upd_cyc0", 64'(at(upd_cyc, 0)), 64'(t0 + 1));
        chk("same_upd_cyc1", 64'(at(upd_cyc, 1)), 64'(t0 + 3));

        // Different sets back to back: one update per cycle
        clear_logs();
        push_rec(32'h0000_0004, 1'b1, 32'h0000_0100, 1'b1);
        t0 = cyc;
        push_rec(32'h0000_0008, 1'b0, 32'h0000_0200, 1'b1);
        push_rec(32'h0000_000C, 1'b1, 32'h0000_0300, 1'b1);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("diff_rd_cyc%0d", i), 64'(at(rd_cyc, i)), 64'(t0 + i));
            chk($sformatf("diff_rd_set%0d", i), 64'(at(rd_set, i)), 64'(i + 1));
            chk($sformatf("diff_upd_cyc%0d", i), 64'(at(upd_cyc, i)), 64'(t0 + 1 + i));
        end

        // Same-set stream fills the FIFO: 7 accepted, the 8th dropped
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            push_rec(32'h0000_0004 + 32'(32 * i), 1'(i), 32'h0000_0A00 + 32'(i), (i < 7));
            if (i == 6) chk("full_res_ready", 64'(res_ready), 64'(0));
        end
        chk("drop_cnt_one", 64'(drop_cnt), 64'(1));
        idle(20);
        chk("fill_sb_empty", 64'(sb.size()), 64'(0));
        chk("fill_upd_count", 64'(upd_cyc.size()), 64'(7));

        // Continuous same-set stream: hundreds of drops saturate the counter
        sb_off     = 1'b1;
        res_valid  = 1'b1;
        res_pc     = 32'h0000_0004;
        res_taken  = 1'b1;
        res_target = 32'h0000_0C00;
        repeat (700) @(posedge clk);
        #1;
        res_valid = 1'b0;
        chk("drop_cnt_sat", 64'(drop_cnt), 64'(255));
        rst = 1'b0;
        #1;
        chk("sat_rst_drop_cnt", 64'(drop_cnt), 64'(0));
        chk("sat_rst_res_ready", 64'(res_ready), 64'(1));
        idle(2);
        sb.delete();
        clear_logs();
        sb_off = 1'b0;
        rst = 1'b1;

        // Reset mid-flight with 3 queued and U valid; only the first two update
        for (int i = 0; i < 6; i++) begin
            push_rec(32'h0000_0008 + 32'(32 * i), 1'b0, 32'h0000_0E00 + 32'(i), (i < 2));
        end
        chk("pre_rst_update_en", 64'(update_en), 64'(1));
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        chk("mid_rst_update_en", 64'(update_en), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_rd_req_en", 64'(rd_req_en), 64'(0));
        chk("mid_rst_res_ready", 64'(res_ready), 64'(1));
        idle(2);
        rst = 1'b1;
        push_rec(32'h0000_0010, 1'b1, 32'h0000_5000, 1'b1);
        t0 = cyc;
        idle(10);
        chk("post_rst_sb_empty", 64'(sb.size()), 64'(0));
        chk("post_rst_upd_count", 64'(upd_cyc.size()), 64'(3));
        chk("post_rst_upd_cyc", 64'(at(upd_cyc, 2)), 64'(t0 + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
